if_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage RISC pipeline. Owns the fetch PC and issues in-order requests to instruction memory.

---
 rtl/risc_pkg.sv | 21 ++
 rtl/if_fetch_buffer.sv | 68 ++++++
 rtl/if_fetch_stage.sv | 154 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared types and constants for the RISC pipeline front end.
// Contents: XLEN, NOP_INSTR, fetch FSM state type and fetch-buffer entry type.
package risc_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_DRAIN
  } if_state_e;

  // One buffered fetch: requested PC, returned word, and whether it has returned
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            filled;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_buffer.sv
// Circular buffer of in-flight fetches. Entries are allocated at grant time,
// filled in order as responses return, and popped from the head by IF/ID.
// Ports: clk, reset (async, active-low), flush, alloc/alloc_pc, fill/fill_instr,
//        pop, head (oldest entry), count (allocated), unfilled (awaiting data).
module if_fetch_buffer
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         alloc,
  input  logic [XLEN-1:0]              alloc_pc,
  input  logic                         fill,
  input  logic [31:0]                  fill_instr,
  input  logic                         pop,
  output if_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   unfilled
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if_entry_t       entries [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   fill_ptr;

  assign head = entries[head_ptr];

  // Pointer and entry update; a fill may target the entry being popped (bypass)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
      end
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      unfilled  <= '0;
    end else if (flush) begin
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      unfilled  <= '0;
    end else begin
      if (alloc) begin
        entries[alloc_ptr] <= '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
        alloc_ptr          <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        entries[fill_ptr].instr  <= fill_instr;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr                 <= fill_ptr + PW'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      count    <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill);
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests,
// buffers up to FIFO_DEPTH fetches and drives the IF/ID register.
// Ports: clk, reset (async, active-low), stall, branch_taken, branch_target,
//        imem_req/imem_addr/imem_gnt, imem_rvalid/imem_rdata,
//        if_id_valid/if_id_pc/if_id_instr.
// Optional: IF_PERF_CNT_EN adds perf_fetched and perf_bubbles counters.
module if_fetch_stage
  import risc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  if_state_e       state, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [CW-1:0]   drop_q, drop_n;
  logic [CW-1:0]   count_n;
  logic            req_n;
  logic            granted, rsp_ok, head_ready;
  logic            alloc, fill, pop, flush;
  logic [31:0]     load_instr;
  if_entry_t       head;
  logic [CW-1:0]   buf_count, buf_unfilled;

  if_fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .alloc      (alloc),
    .alloc_pc   (pc_q),
    .fill       (fill),
    .fill_instr (imem_rdata),
    .pop        (pop),
    .head       (head),
    .count      (buf_count),
    .unfilled   (buf_unfilled)
  );

  assign imem_addr  = pc_q;
  // Head word may arrive this very cycle; forward it straight into IF/ID
  assign load_instr = head.filled ? head.instr : imem_rdata;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_BOOT;
    else        state <= state_n;
  end

  // Next state, buffer control, and next request/PC
  always_comb begin
    state_n    = state;
    pc_n       = pc_q;
    drop_n     = drop_q;
    alloc      = 1'b0;
    fill       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    granted    = imem_req & imem_gnt;
    rsp_ok     = imem_rvalid && (state == S_FETCH) && (buf_unfilled != '0);
    head_ready = (buf_count != '0) && (head.filled || rsp_ok);

    if (branch_taken) pc_n = branch_target & ~XLEN'(3);

    case (state)
      S_BOOT: state_n = S_FETCH;
      S_FETCH: begin
        if (branch_taken) begin
          // Everything in flight is discarded; a response landing now is already gone
          flush  = 1'b1;
          drop_n = buf_unfilled + CW'(granted) - CW'(rsp_ok);
          if (drop_n != '0) state_n = S_DRAIN;
        end else begin
          alloc = granted;
          fill  = rsp_ok;
          pop   = !stall && head_ready;
          if (granted) pc_n = pc_q + XLEN'(4);
        end
      end
      S_DRAIN: begin
        if (imem_rvalid && (drop_q != '0)) drop_n = drop_q - CW'(1);
        if (drop_n == '0) state_n = S_FETCH;
      end
      default: state_n = S_BOOT;
    endcase

    count_n = flush ? '0 : (buf_count + CW'(alloc) - CW'(pop));
    req_n   = (state_n == S_FETCH) && (count_n < CW'(FIFO_DEPTH));
  end

  // PC, drop counter, request and IF/ID register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      drop_q      <= '0;
      imem_req    <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else begin
      pc_q     <= pc_n;
      drop_q   <= drop_n;
      imem_req <= req_n;
      if (branch_taken) begin
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if_id_valid <= pop;
        if (pop) begin
          if_id_pc    <= head.pc;
          if_id_instr <= load_instr;
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Loads and non-stalled empty cycles, free-running with wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop)            perf_fetched <= perf_fetched + 32'(1);
      if (!stall && !pop) perf_bubbles <= perf_bubbles + 32'(1);
    end
  end
`endif

  // Every response must belong to a request still being filled or drained
  assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> (((state == S_FETCH) && (buf_unfilled != '0)) || (state == S_DRAIN)))
  else $error("if_fetch_stage: imem_rvalid with nothing outstanding");

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  import risc_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  if_fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: in-order queue of granted addresses
  typedef struct { logic [31:0] addr; int k; } req_t;
  req_t q[$];
  int   gnt_mode;   // 0 never, 1 always, 2 random
  int   rsp_mode;   // 0 hold, 1 earliest, 2 random
  int   cyc;

  // Reference model of the architectural fetch stream
  logic [31:0] exp_pc, fetch_exp;
  logic        p_req, p_valid;
  logic [31:0] p_addr, p_pc, p_instr;
  int          loads;

  int checks, errors;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: memory answers, edge, then model checks at the falling edge
  task automatic cycle();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (q.size() > 0 && q[0].k < cyc) begin
      if (rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(0, 2) != 0)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(q[0].addr);
        void'(q.pop_front());
      end
    end
    imem_gnt = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 3) != 0);
    if (imem_req && imem_gnt) begin
      chk("grant_addr", imem_addr, fetch_exp);
      q.push_back('{addr: imem_addr, k: cyc});
      fetch_exp = fetch_exp + 32'd4;
    end
    p_req   = imem_req;
    p_addr  = imem_addr;
    p_valid = if_id_valid;
    p_pc    = if_id_pc;
    p_instr = if_id_instr;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (branch_taken) begin
      chk("branch_valid", 32'(if_id_valid), 32'd0);
      exp_pc    = branch_target & ~32'd3;
      fetch_exp = branch_target & ~32'd3;
    end else begin
      if (p_req && !imem_gnt) begin
        chk("hold_req", 32'(imem_req), 32'd1);
        chk("hold_addr", imem_addr, p_addr);
      end
      if (stall) begin
        chk("stall_valid", 32'(if_id_valid), 32'(p_valid));
        chk("stall_pc", if_id_pc, p_pc);
        chk("stall_instr", if_id_instr, p_instr);
      end else if (if_id_valid) begin
        chk("stream_pc", if_id_pc, exp_pc);
        chk("stream_instr", if_id_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        loads++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;

    // Reset release, full-rate memory, then a 3-cycle stall mid-stream
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h08};
    tbl[6]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h08};
    tbl[7]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h08};
    tbl[8]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[9]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[10] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[11] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h18};

    checks = 0; errors = 0; loads = 0; cyc = 0;
    gnt_mode = 1; rsp_mode = 1;
    exp_pc = RST_PC; fetch_exp = RST_PC;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_instr", if_id_instr, NOP_INSTR);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      stall = tbl[i].stall;
      cycle();
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(if_id_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_pc", i), if_id_pc, tbl[i].pc);
      if (tbl[i].valid) chk($sformatf("tbl%0d_instr", i), if_id_instr, mem_word(tbl[i].pc));
    end
    stall = 1'b0;

    // Redirect with two responses still outstanding
    rsp_mode = 0;
    cycle();
    chk("br_pre_req", 32'(imem_req), 32'd0);
    chk("br_pre_outstanding", 32'(q.size()), 32'd2);
    branch_taken = 1'b1; branch_target = 32'h40;
    cycle();
    branch_taken = 1'b0;
    chk("br_drain_req", 32'(imem_req), 32'd0);
    rsp_mode = 1;
    n = 0;
    while (!imem_req && n < 20) begin cycle(); n++; end
    chk("br_req_after_drain", 32'(imem_req), 32'd1);
    chk("br_addr_after_drain", imem_addr, 32'h40);
    n = 0;
    while (!if_id_valid && n < 20) begin cycle(); n++; end
    chk("br_first_valid", 32'(if_id_valid), 32'd1);
    chk("br_first_pc", if_id_pc, 32'h40);

    // Unaligned target, redirect during stall
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h43;
    cycle();
    branch_taken = 1'b0; stall = 1'b0;
    chk("br_stall_valid", 32'(if_id_valid), 32'd0);
    n = 0;
    while (!if_id_valid && n < 20) begin cycle(); n++; end
    chk("unaligned_pc", if_id_pc, 32'h40);
    chk("unaligned_instr", if_id_instr, mem_word(32'h40));

    // Grant withheld: request and address must hold
    gnt_mode = 0;
    repeat (4) cycle();
    chk("nognt_req", 32'(imem_req), 32'd1);
    a = imem_addr;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("nognt_req_hold", 32'(imem_req), 32'd1);
      chk("nognt_addr_hold", imem_addr, a);
    end
    gnt_mode = 1;
    cycle();
    chk("gnt_advance", imem_addr, a + 32'd4);

    // Redirect near the top of the address space, fetch wraps to zero
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFB;
    cycle();
    branch_taken = 1'b0;
    n = 0;
    while (!(if_id_valid && if_id_pc == 32'h0) && n < 40) begin cycle(); n++; end
    chk("wrap_to_zero", 32'(if_id_valid && if_id_pc == 32'h0), 32'd1);

    // Reset asserted in the middle of a drain
    rsp_mode = 0;
    n = 0;
    while (imem_req && n < 20) begin cycle(); n++; end
    chk("pre_reset_full", 32'(imem_req), 32'd0);
    branch_taken = 1'b1; branch_target = 32'h80;
    cycle();
    branch_taken = 1'b0;
    chk("pre_reset_outstanding", 32'(q.size() != 0), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, RST_PC);
    chk("arst_valid", 32'(if_id_valid), 32'd0);
    chk("arst_pc", if_id_pc, 32'd0);
    chk("arst_instr", if_id_instr, NOP_INSTR);
    q.delete();
    exp_pc = RST_PC; fetch_exp = RST_PC;
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    reset = 1'b1;
    rsp_mode = 1; gnt_mode = 1;
    n = 0;
    while (!imem_req && n < 10) begin cycle(); n++; end
    chk("post_reset_addr", imem_addr, RST_PC);
    n = 0;
    while (!if_id_valid && n < 20) begin cycle(); n++; end
    chk("post_reset_pc", if_id_pc, RST_PC);
    chk("post_reset_instr", if_id_instr, mem_word(RST_PC));

    // Randomised grant/response timing, stalls and redirects
    gnt_mode = 2; rsp_mode = 2;
    loads = 0;
    for (int i = 0; i < 2000; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 24) == 0);
      branch_target = $urandom();
      cycle();
    end
    branch_taken = 1'b0; stall = 1'b0;
    chk("random_progress", 32'(loads > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
